// File: rtl/call_stack.sv
// Return-address stack for CALL/RET. The top entry is visible combinationally so a RET
// can use it in the same cycle. Optional build macro: CALL_STACK_WRAP_EN (circular push when full).
module call_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       stall,
    input  logic [AW-1:0]              push_addr,
    output logic [AW-1:0]              ret_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       udf
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = SPW + 1;

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic           wr_en;
    logic [SPW-1:0] wr_idx;
    logic [SPW-1:0] top_idx;
    logic           is_empty;
    logic           is_full;

    assign top_idx  = sp_q - SPW'(1);
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(DEPTH));

    assign ret_addr = is_empty ? '0 : mem_q[top_idx];
    assign count    = cnt_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (!stall) begin
            case ({push, pop})
                2'b10: begin
                    if (!is_full) begin
                        wr_en = 1'b1;
                        sp_d  = sp_q + SPW'(1);
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        // Circular: overwrite the oldest entry, count stays at DEPTH.
                        wr_en = 1'b1;
                        sp_d  = sp_q + SPW'(1);
`endif
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        sp_d  = sp_q - SPW'(1);
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        udf_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (!is_empty) begin
                        // RET followed by CALL: replace the top in place.
                        wr_en  = 1'b1;
                        wr_idx = top_idx;
                    end else begin
                        wr_en = 1'b1;
                        sp_d  = sp_q + SPW'(1);
                        cnt_d = CW'(1);
                        udf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage carries no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= push_addr;
        end
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of return-address entries (power of two, minimum 2).
REQ-002 SHALL have parameter AW, default 19, giving the address width in bits, matching the 19-bit PC.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port push, input, 1, which pushes push_addr (driven from decoder ID_push on CALL).
REQ-006 SHALL have port pop, input, 1, which pops the top entry (driven from decoder ID_pop on RET).
REQ-007 SHALL have port stall, input, 1, which holds all state while high and ignores push/pop.
REQ-008 SHALL have port push_addr, input, AW, the return address (PC+1 of the CALL).
REQ-009 SHALL have port ret_addr, output, AW, the current top-of-stack entry.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, the number of valid entries.
REQ-011 SHALL have port empty, output, 1, asserted when count==0.
REQ-012 SHALL have port full, output, 1, asserted when count==DEPTH.
REQ-013 SHALL have port ovf, output, 1, the sticky overflow flag.
REQ-014 SHALL have port udf, output, 1, the sticky underflow flag.

Function
REQ-015 SHALL store entries in a DEPTH x AW register array indexed by a stack pointer sp of width $clog2(DEPTH); sp addresses the next free slot.
REQ-016 SHALL drive ret_addr combinationally from array[sp-1] (modulo DEPTH) when count>0, and 0 when empty, so a RET sees the target in the same cycle that pop is asserted.
REQ-017 SHALL, on push only and not full: write array[sp]<=push_addr, sp<=sp+1, count<=count+1; the new top is visible on ret_addr the next cycle.
REQ-018 SHALL, on pop only and not empty: set sp<=sp-1 and count<=count-1; the array contents are unchanged.
REQ-019 SHALL, on pop only while empty: leave sp and count unchanged and set udf<=1.
REQ-020 SHALL, on push and pop together while not empty: overwrite the top entry (array[sp-1]<=push_addr) and leave sp and count unchanged.
REQ-021 SHALL, on push and pop together while empty: behave as push only, with count becoming 1, and set udf<=1.
REQ-022 SHALL, on push only while full: behave as defined in REQ-027/REQ-028 and set ovf<=1.
REQ-023 SHALL, while stall=1: hold sp, count, the array, ovf and udf regardless of push/pop; ret_addr continues to reflect the held top.
REQ-024 SHALL keep ovf and udf asserted once set, until rst.
REQ-025 SHALL perform all pointer arithmetic modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, set sp=0, count=0, ovf=0 and udf=0, so that empty=1, full=0 and ret_addr=0 from the next cycle; rst SHALL override push, pop and stall, and array contents need not be cleared.

Configuration
REQ-027 SHALL, with CALL_STACK_WRAP_EN defined, treat a push while full as circular: write array[sp]<=push_addr, sp<=sp+1 and hold count at DEPTH, overwriting the oldest entry.
REQ-028 SHALL, without CALL_STACK_WRAP_EN, discard a push while full, leaving sp, count and the array unchanged.

Verification
REQ-029 SHALL cover: rst; push 0x00010, push 0x00020 -> count=2, ret_addr=0x00020; pop -> ret_addr=0x00020 during the pop cycle, then 0x00010 with count=1.
REQ-030 SHALL cover: pop at reset (empty) -> udf=1, count=0, ret_addr=0; udf stays 1 until rst.
REQ-031 SHALL cover: push 0x1 to 0x8 (DEPTH=8), then push 0x9 -> full=1, ovf=1; with the macro, ret_addr=0x9 and eight pops return 0x9..0x2; without it, ret_addr=0x8 and pops return 0x8..0x1.
REQ-032 SHALL cover: count=3 with top 0x30, then push=pop=1 with push_addr=0x55 -> count=3, ret_addr=0x55; the same stimulus while empty -> count=1, ret_addr=0x55, udf=1.
REQ-033 SHALL cover: stall=1 with push=1 and push_addr=0x7 for 3 cycles -> count, ret_addr and the flags are unchanged.
REQ-034 SHALL cover: rst asserted in the same cycle as push -> count=0, empty=1, ovf=udf=0 the next cycle.
